// File: rtl/fp16_pkg.sv
// Shared binary16 constants and types for the FP unit (divider and FMA datapaths).
package fp16_pkg;

   localparam int SIGN_W = 1;
   localparam int EXP_W  = 5;
   localparam int FRAC_W = 10;
   localparam int SIG_W  = FRAC_W + 1;
   localparam int BIAS   = 15;

   localparam logic [15:0] QNAN   = 16'h7E00;
   localparam logic [15:0] MAXFIN = 16'h7BFF;
   localparam logic [15:0] INF    = 16'h7C00;

   typedef enum logic [1:0] {
      RM_RZ  = 2'b00,
      RM_RNE = 2'b01,
      RM_RP  = 2'b10,
      RM_RN  = 2'b11
   } rm_e;

   localparam int FLG_NV = 4;
   localparam int FLG_DZ = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ITER  = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } div_state_e;

endpackage

// File: rtl/fp16_round.sv
// Combinational binary16 rounder: rounds an 11-bit significand with guard/sticky and
// resolves exponent overflow/underflow into the final encoding and exception flags.
module fp16_round
   import fp16_pkg::*;
(
   input  logic              sign_i,
   input  logic signed [6:0] e_i,
   input  logic [10:0]       sig_i,
   input  logic              guard_i,
   input  logic              sticky_i,
   input  rm_e               rm_i,
   output logic [15:0]       result_o,
   output logic              of_o,
   output logic              uf_o,
   output logic              nx_o
);

   logic              inexact;
   logic              rnd_up;
   logic [11:0]       sum;
   logic              carry;
   logic [9:0]        frac_r;
   logic signed [6:0] e_r;

   always_comb begin
      inexact = guard_i | sticky_i;
      case (rm_i)
         RM_RNE:  rnd_up = guard_i & (sticky_i | sig_i[0]);
         RM_RP:   rnd_up = ~sign_i & inexact;
         RM_RN:   rnd_up = sign_i & inexact;
         default: rnd_up = 1'b0;
      endcase

      // Only 0x7FF + 1 can reach 0x800; every other sum keeps the hidden bit at [10].
      sum    = {1'b0, sig_i} + {11'd0, rnd_up};
      carry  = (sum[11:10] == 2'b10);
      frac_r = carry ? 10'd0 : sum[9:0];
      e_r    = carry ? (e_i + 7'sd1) : e_i;

      result_o = {sign_i, e_r[4:0], frac_r};
      of_o     = 1'b0;
      uf_o     = 1'b0;
      nx_o     = inexact;

      if (e_r >= 7'sd31) begin
         of_o = 1'b1;
         nx_o = 1'b1;
         case (rm_i)
            RM_RZ:   result_o = {sign_i, MAXFIN[14:0]};
            RM_RNE:  result_o = {sign_i, INF[14:0]};
            RM_RP:   result_o = sign_i ? {1'b1, MAXFIN[14:0]} : INF;
            default: result_o = sign_i ? {1'b1, INF[14:0]} : MAXFIN;
         endcase
      end else if (e_r <= 7'sd0) begin
         result_o = {sign_i, 15'd0};
         uf_o     = 1'b1;
         nx_o     = 1'b1;
      end
   end

endmodule

// File: rtl/fdiv16.sv
// Multi-cycle binary16 divider: special-case screening, 13-step restoring quotient
// iteration, then a shared rounding stage; valid/ready on both request and response.
module fdiv16
   import fp16_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [1:0]  roundmode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic [4:0]  flags
);

   div_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       result_q, result_d;
   logic [4:0]        flags_q, flags_d;

   logic [15:0]       x_q, x_d, y_q, y_d;
   rm_e               rm_q, rm_d;
   logic              sign_q, sign_d;
   logic signed [6:0] e_q, e_d;
   logic [11:0]       rem_q, rem_d;
   logic [10:0]       my_q, my_d;
   logic [12:0]       q_q, q_d;

   logic [4:0]        ex, ey;
   logic [10:0]       mx, my;
   logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;
   logic signed [6:0] exp_diff;
   logic              rem_ge;
   logic [11:0]       rem_sub, rem_sel;

   logic [15:0]       rnd_result;
   logic              rnd_of, rnd_uf, rnd_nx;

   // Operand decode; subnormals (exponent 0) count as zero.
   assign ex       = x_q[14:10];
   assign ey       = y_q[14:10];
   assign mx       = {1'b1, x_q[9:0]};
   assign my       = {1'b1, y_q[9:0]};
   assign x_zero   = (ex == 5'd0);
   assign y_zero   = (ey == 5'd0);
   assign x_inf    = (ex == 5'h1F) && (x_q[9:0] == 10'd0);
   assign y_inf    = (ey == 5'h1F) && (y_q[9:0] == 10'd0);
   assign x_nan    = (ex == 5'h1F) && (x_q[9:0] != 10'd0);
   assign y_nan    = (ey == 5'h1F) && (y_q[9:0] != 10'd0);
   assign x_snan   = x_nan & ~x_q[9];
   assign y_snan   = y_nan & ~y_q[9];
   assign exp_diff = $signed({2'b00, ex}) - $signed({2'b00, ey});

   assign rem_ge   = (rem_q >= {1'b0, my_q});
   assign rem_sub  = rem_q - {1'b0, my_q};
   assign rem_sel  = rem_ge ? rem_sub : rem_q;

   fp16_round u_round (
      .sign_i   (sign_q),
      .e_i      (e_q),
      .sig_i    (q_q[12:2]),
      .guard_i  (q_q[1]),
      .sticky_i (q_q[0] | (rem_q != 12'd0)),
      .rm_i     (rm_q),
      .result_o (rnd_result),
      .of_o     (rnd_of),
      .uf_o     (rnd_uf),
      .nx_o     (rnd_nx)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      x_d      = x_q;
      y_d      = y_q;
      rm_d     = rm_q;
      sign_d   = sign_q;
      e_d      = e_q;
      rem_d    = rem_q;
      my_d     = my_q;
      q_d      = q_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = x;
               y_d     = y;
               rm_d    = rm_e'(roundmode);
               state_d = CHECK;
            end
         end
         CHECK: begin
            sign_d  = x_q[15] ^ y_q[15];
            cnt_d   = 4'd0;
            flags_d = 5'd0;
            state_d = DONE;
            if (x_nan | y_nan) begin
               result_d        = QNAN;
               flags_d[FLG_NV] = x_snan | y_snan;
            end else if ((x_zero & y_zero) | (x_inf & y_inf)) begin
               result_d        = QNAN;
               flags_d[FLG_NV] = 1'b1;
            end else if (y_zero & ~x_inf) begin
               result_d        = {x_q[15] ^ y_q[15], INF[14:0]};
               flags_d[FLG_DZ] = 1'b1;
            end else if (x_inf) begin
               result_d = {x_q[15] ^ y_q[15], INF[14:0]};
            end else if (x_zero | y_inf) begin
               result_d = {x_q[15] ^ y_q[15], 15'd0};
            end else begin
               // Pre-normalise so the first quotient bit is always 1.
               state_d = ITER;
               my_d    = my;
               q_d     = 13'd0;
               if (mx < my) begin
                  rem_d = {mx, 1'b0};
                  e_d   = exp_diff + 7'sd14;
               end else begin
                  rem_d = {1'b0, mx};
                  e_d   = exp_diff + 7'sd15;
               end
            end
         end
         ITER: begin
            q_d   = {q_q[11:0], rem_ge};
            rem_d = rem_sel << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd12) state_d = ROUND;
         end
         ROUND: begin
            result_d = rnd_result;
            flags_d  = {2'b00, rnd_of, rnd_uf, rnd_nx};
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         result_q <= 16'h0000;
         flags_q  <= 5'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   always_ff @(posedge clk) begin
      x_q    <= x_d;
      y_q    <= y_d;
      rm_q   <= rm_d;
      sign_q <= sign_d;
      e_q    <= e_d;
      rem_q  <= rem_d;
      my_q   <= my_d;
      q_q    <= q_d;
   end

   assign in_ready  = reset_n & (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv16.sv
// Scenario bench for fdiv16: expected responses are queued at issue time and
// popped when the divider raises out_valid.
module tb_fdiv16;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic [1:0]  roundmode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [4:0]  flags;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] res;
      logic [4:0]  flg;
      int          lat;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  rm;
      logic [15:0] res;
      logic [4:0]  flg;
   } vec_t;

   exp_t sb[$];

   fdiv16 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .roundmode (roundmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request and wait (bounded) for the response; lat counts edges after accept.
   task automatic do_req(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                         output logic [15:0] r, output logic [4:0] f, output int lat);
      int wait_cnt;
      wait_cnt = 0;
      @(negedge clk);
      while (!in_ready && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      x = a;
      y = b;
      roundmode = rm;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = result;
      f = flags;
   endtask

   task automatic release_rsp();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
      checks++;
      if (flags !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", flags); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_normal();
      vec_t        v[$];
      exp_t        e;
      logic [15:0] r;
      logic [4:0]  f;
      int          lat;
      v.push_back('{16'h3C00, 16'h4000, 2'b01, 16'h3800, 5'b00000});
      v.push_back('{16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'b00001});
      v.push_back('{16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'b00001});
      v.push_back('{16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'b00001});
      v.push_back('{16'hBC00, 16'h4200, 2'b11, 16'hB556, 5'b00001});
      v.push_back('{16'h7BFF, 16'h1400, 2'b00, 16'h7BFF, 5'b00101});
      v.push_back('{16'h7BFF, 16'h1400, 2'b01, 16'h7C00, 5'b00101});
      v.push_back('{16'hFBFF, 16'h1400, 2'b10, 16'hFBFF, 5'b00101});
      v.push_back('{16'h7BFF, 16'h1400, 2'b11, 16'h7BFF, 5'b00101});
      v.push_back('{16'h7BFF, 16'h3C00, 2'b01, 16'h7BFF, 5'b00000});
      v.push_back('{16'h0400, 16'h7800, 2'b01, 16'h0000, 5'b00011});
      foreach (v[i]) begin
         sb.push_back('{v[i].res, v[i].flg, 15});
         do_req(v[i].a, v[i].b, v[i].rm, r, f, lat);
         e = sb.pop_front();
         checks++;
         if (r !== e.res) begin errors++; $display("FAIL normal[%0d] result %h/%h got %h want %h", i, v[i].a, v[i].b, r, e.res); end
         checks++;
         if (f !== e.flg) begin errors++; $display("FAIL normal[%0d] flags got %b want %b", i, f, e.flg); end
         checks++;
         if (lat != e.lat) begin errors++; $display("FAIL normal[%0d] latency got %0d want %0d", i, lat, e.lat); end
         release_rsp();
      end
   endtask

   task automatic test_special();
      vec_t        v[$];
      exp_t        e;
      logic [15:0] r;
      logic [4:0]  f;
      int          lat;
      v.push_back('{16'h3C00, 16'h0000, 2'b01, 16'h7C00, 5'b01000});
      v.push_back('{16'hBC00, 16'h0000, 2'b01, 16'hFC00, 5'b01000});
      v.push_back('{16'h0000, 16'h0000, 2'b01, 16'h7E00, 5'b10000});
      v.push_back('{16'h7C00, 16'h7C00, 2'b01, 16'h7E00, 5'b10000});
      v.push_back('{16'h7D00, 16'h3C00, 2'b01, 16'h7E00, 5'b10000});
      v.push_back('{16'h3C00, 16'h7E00, 2'b01, 16'h7E00, 5'b00000});
      v.push_back('{16'h7C00, 16'hC000, 2'b01, 16'hFC00, 5'b00000});
      v.push_back('{16'h8000, 16'h3C00, 2'b01, 16'h8000, 5'b00000});
      v.push_back('{16'h3C00, 16'h7C00, 2'b01, 16'h0000, 5'b00000});
      v.push_back('{16'h0001, 16'hBC00, 2'b01, 16'h8000, 5'b00000});
      foreach (v[i]) begin
         sb.push_back('{v[i].res, v[i].flg, 1});
         do_req(v[i].a, v[i].b, v[i].rm, r, f, lat);
         e = sb.pop_front();
         checks++;
         if (r !== e.res) begin errors++; $display("FAIL special[%0d] result %h/%h got %h want %h", i, v[i].a, v[i].b, r, e.res); end
         checks++;
         if (f !== e.flg) begin errors++; $display("FAIL special[%0d] flags got %b want %b", i, f, e.flg); end
         checks++;
         if (lat != e.lat) begin errors++; $display("FAIL special[%0d] latency got %0d want %0d", i, lat, e.lat); end
         release_rsp();
      end
   endtask

   task automatic test_backpressure();
      exp_t        e;
      logic [15:0] r;
      logic [4:0]  f;
      int          lat;
      sb.push_back('{16'hC200, 5'b00000, 15});
      do_req(16'hC600, 16'h4000, 2'b01, r, f, lat);
      e = sb.pop_front();
      checks++;
      if (r !== e.res) begin errors++; $display("FAIL bp result got %h want %h", r, e.res); end
      checks++;
      if (f !== e.flg) begin errors++; $display("FAIL bp flags got %b want %b", f, e.flg); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL bp latency got %0d want %0d", lat, e.lat); end
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] out_valid got %b want 1", i, out_valid); end
         checks++;
         if (result !== e.res) begin errors++; $display("FAIL bp_hold[%0d] result got %h want %h", i, result, e.res); end
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] in_ready got %b want 0", i, in_ready); end
      end
      in_valid = 1'b0;
      release_rsp();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release out_valid got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      exp_t        e;
      logic [15:0] r;
      logic [4:0]  f;
      int          lat;
      bit          saw;
      @(negedge clk);
      x = 16'h3C00;
      y = 16'h4200;
      roundmode = 2'b01;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst in_ready got %b want 0", in_ready); end
      checks++;
      if (result !== 16'h0000) begin errors++; $display("FAIL midrst result got %h want 0000", result); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release in_ready got %b want 1", in_ready); end
      saw = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin errors++; $display("FAIL midrst_abort out_valid seen got %b want 0", saw); end
      sb.push_back('{16'h3800, 5'b00000, 15});
      do_req(16'h3C00, 16'h4000, 2'b01, r, f, lat);
      e = sb.pop_front();
      checks++;
      if (r !== e.res) begin errors++; $display("FAIL recover result got %h want %h", r, e.res); end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL recover latency got %0d want %0d", lat, e.lat); end
      release_rsp();
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = 16'h0000;
      y         = 16'h0000;
      roundmode = 2'b00;
      test_reset();
      test_normal();
      test_special();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
